// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: glyph patterns and bit positions.
package seven_seg_scan_ctrl_pkg;

  // Segment bit positions on the o_seg bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // A-G glyph patterns, active-high (lit = 1)
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ERR = 7'h79;  // "E" for non-BCD nibbles

endpackage

// File: rtl/seven_seg_scan_ctrl_seg_digit_lut.sv
// Combinational BCD nibble to A-G glyph lookup; non-BCD codes show "E".
module seg_digit_lut
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph table lookup
  always_comb begin
    seg_o = SEG_ERR;
    case (nibble_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit time-multiplexed 7-segment scan controller with a pending/active word
// pair so a new value only takes effect at a frame boundary (no tearing).
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_BCD,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_en,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_dig,
  output logic        o_frame
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [7:0]    SEG_OFF   = {8{SEG_ACTIVE_LOW}};
  localparam logic [3:0]    DIG_OFF   = {4{DIG_ACTIVE_LOW}};

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          pend_full_q;
  logic [15:0]   pend_bcd_q, act_bcd_q;
  logic [3:0]    pend_dp_q, act_dp_q;
  logic          pend_lzb_q, act_lzb_q;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          frame_q, frame_d;

  logic          slot_last, transfer, commit, in_blank, lz_blank;
  logic [3:0]    sel_nib;
  logic [6:0]    glyph;

  assign o_ready = ~pend_full_q;
  assign o_seg   = seg_q;
  assign o_dig   = dig_q;
  assign o_frame = frame_q;

  // Single LUT after the digit mux
  seg_digit_lut u_lut (
    .nibble_i (sel_nib),
    .seg_o    (glyph)
  );

  // Slot bookkeeping, handshake/commit decisions and next output values
  always_comb begin
    slot_last = (cnt_q == CNT_LAST);
    frame_d   = i_en && slot_last && (idx_q == 2'd3);
    transfer  = i_valid && ~pend_full_q;
    // Disabled scan has no frame boundary to wait for, so commit at once
    commit    = pend_full_q && (i_en ? frame_d : 1'b1);
    in_blank  = (cnt_q < BLANK_END);
    sel_nib   = act_bcd_q[{idx_q, 2'b00} +: 4];
    // Blank a leading zero when this nibble and everything above it is zero
    lz_blank  = act_lzb_q && (idx_q != 2'd0) && ((act_bcd_q >> {idx_q, 2'b00}) == 16'h0000);
    seg_d     = SEG_OFF;
    dig_d     = DIG_OFF;
    if (i_en && !in_blank) begin
      seg_d         = {act_dp_q[idx_q], (lz_blank ? 7'h00 : glyph[SEG_G:SEG_A])} ^ SEG_OFF;
      dig_d         = (4'b0001 << idx_q) ^ DIG_OFF;
      seg_d[SEG_DP] = act_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_full_q <= 1'b0;
      pend_bcd_q  <= 16'h0000;
      pend_dp_q   <= 4'h0;
      pend_lzb_q  <= 1'b0;
      act_bcd_q   <= 16'h0000;
      act_dp_q    <= 4'h0;
      act_lzb_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      dig_q       <= DIG_OFF;
      frame_q     <= 1'b0;
    end else begin
      if (!i_en) begin
        cnt_q <= '0;
        idx_q <= 2'd0;
      end else if (slot_last) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (transfer) begin
        pend_full_q <= 1'b1;
        pend_bcd_q  <= i_BCD;
        pend_dp_q   <= i_dp;
        pend_lzb_q  <= i_lzb;
      end else if (commit) begin
        pend_full_q <= 1'b0;
        act_bcd_q   <= pend_bcd_q;
        act_dp_q    <= pend_dp_q;
        act_lzb_q   <= pend_lzb_q;
      end

      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: every cycle the pins are compared to a frame-position model.
module tb_seven_seg_scan_ctrl;

  localparam int CD    = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * CD;
  localparam logic [7:0] SEG_MASK = 8'h00;  // SEG_ACTIVE_LOW = 0
  localparam logic [3:0] DIG_MASK = 4'hF;   // DIG_ACTIVE_LOW = 1

  logic        clk = 1'b0;
  logic        rst, valid, lzb, en;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        ready, frame;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int total = 0;
  int bad   = 0;

  // Model: position within the 4-digit frame plus pending/active words
  int          pos;
  logic        m_pfull, m_alzb, m_plzb;
  logic [15:0] m_abcd, m_pbcd;
  logic [3:0]  m_adp, m_pdp;
  logic [6:0]  pat [16];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .CLK_DIV(CD), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_BCD(bcd), .i_dp(dp), .i_lzb(lzb), .i_valid(valid),
    .o_ready(ready), .i_en(en), .o_seg(seg), .o_dig(dig), .o_frame(frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict pins from the current model/input state, advance the model, compare
  task automatic step();
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_frm, commit;
    int          d, w;
    logic [15:0] upper;
    e_seg = 8'h00;
    e_dig = 4'h0;
    e_frm = 1'b0;
    if (!rst) begin
      d = pos / CD;
      w = pos % CD;
      e_frm = en && (pos == FRAME - 1);
      if (en && w >= BLANK) begin
        upper = m_abcd >> (4 * d);
        e_dig = 4'(1 << d);
        e_seg = {m_adp[d], (m_alzb && d > 0 && upper == 16'h0) ? 7'h00 : pat[upper[3:0]]};
      end
    end
    if (rst) begin
      pos = 0; m_pfull = 0; m_abcd = 0; m_adp = 0; m_alzb = 0;
    end else begin
      commit = m_pfull && (en ? e_frm : 1'b1);
      if (!m_pfull && valid) begin
        m_pfull = 1; m_pbcd = bcd; m_pdp = dp; m_plzb = lzb;
      end else if (commit) begin
        m_pfull = 0; m_abcd = m_pbcd; m_adp = m_pdp; m_alzb = m_plzb;
      end
      pos = en ? (pos + 1) % FRAME : 0;
    end
    @(posedge clk);
    #1;
    chk("seg", seg, e_seg ^ SEG_MASK);
    chk("dig", dig, e_dig ^ DIG_MASK);
    chk("frame", frame, e_frm);
    chk("ready", ready, !m_pfull);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    int frames;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    pos = 0; m_pfull = 0; m_abcd = 0; m_adp = 0; m_alzb = 0;
    m_pbcd = 0; m_pdp = 0; m_plzb = 0;
    rst = 1; en = 1; valid = 0; bcd = 0; dp = 0; lzb = 0;

    // Reset, then free-running scan of the all-zero word
    run(3);
    rst = 0;
    frames = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame) frames++;
    end
    chk("frame_count", frames, 2);

    // Load 1234 mid-frame, then hold 5678 while pending is full
    run(5);
    valid = 1; bcd = 16'h1234; dp = 4'h0; lzb = 0;
    step();
    bcd = 16'h5678;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (frame) found = 1;
    end
    chk("frame_1234", found, 1);
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      step();
      if (dig === 4'b1110) found = 1;
    end
    chk("d0_found", found, 1);
    chk("d0_1234", seg, 8'h66);
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      step();
      if (dig === 4'b0111) found = 1;
    end
    chk("d3_found", found, 1);
    chk("d3_1234", seg, 8'h06);
    valid = 0;
    run(2 * FRAME);

    // Leading-zero blank with decimal point on a blanked digit
    valid = 1; bcd = 16'h0040; dp = 4'b0100; lzb = 1;
    step();
    valid = 0;
    run(2 * FRAME);

    // Non-BCD nibbles
    valid = 1; bcd = 16'hF00A; dp = 4'h0; lzb = 0;
    step();
    valid = 0;
    run(2 * FRAME);

    // Disable mid-slot, immediate commit, re-enable, reset mid-handshake
    run(CD + 4);
    en = 0;
    run(3);
    valid = 1; bcd = 16'h9876; dp = 4'b1001;
    step();
    valid = 0;
    run(4);
    en = 1;
    run(FRAME + 4);
    valid = 1; bcd = 16'h4321;
    step();
    valid = 0;
    rst = 1;
    step();
    rst = 0;
    run(FRAME + 2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(0, 9) < 3);
      bcd   = 16'($urandom);
      dp    = 4'($urandom);
      lzb   = 1'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
      rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; en = 1; valid = 0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
